// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding one UART transmitter from NUM_REQ byte requesters.
// Define UART_TX_ARB_TIMEOUT_EN to add a SEND watchdog that aborts after TIMEOUT_CYCLES.
module uart_tx_arb #(
   parameter int NUM_REQ        = 4,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic                          clk_sys,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            ack,
   output logic [NUM_REQ-1:0]            done,
   output logic                          tx_valid,
   output logic [DATA_WIDTH-1:0]         tx_data,
   input  logic                          tx_done,
   output logic                          busy,
   output logic                          err
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t                             state, state_nxt;
   logic [IW-1:0]                      owner, owner_nxt;
   logic [IW-1:0]                      last, last_nxt;
   logic [IW-1:0]                      sel, cand;
   logic                               found;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] bytes;
   logic [NUM_REQ-1:0]                 ack_nxt, done_nxt;
   logic                               tx_valid_nxt;
   logic [DATA_WIDTH-1:0]              tx_data_nxt;

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WW-1:0] wd_cnt, wd_nxt;
   logic          err_nxt;
`else
   assign err = 1'b0;
`endif

   assign bytes = req_data;

   // Search starts just past the last winner so every requester gets a turn.
   always_comb begin
      sel   = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IW'((int'(last) + k) % NUM_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      owner_nxt    = owner;
      last_nxt     = last;
      ack_nxt      = '0;
      done_nxt     = '0;
      tx_valid_nxt = tx_valid;
      tx_data_nxt  = tx_data;
`ifdef UART_TX_ARB_TIMEOUT_EN
      wd_nxt       = '0;
      err_nxt      = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt    = SEND;
               tx_valid_nxt = 1'b1;
               tx_data_nxt  = bytes[sel];
               ack_nxt[sel] = 1'b1;
               owner_nxt    = sel;
               last_nxt     = sel;
            end
         end
         SEND: begin
            if (tx_done) begin
               state_nxt       = GAP;
               tx_valid_nxt    = 1'b0;
               done_nxt[owner] = 1'b1;
            end
`ifdef UART_TX_ARB_TIMEOUT_EN
            else if (wd_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
               // Abort: the owner gets err instead of done and is not retried.
               state_nxt    = GAP;
               tx_valid_nxt = 1'b0;
               err_nxt      = 1'b1;
            end else begin
               wd_nxt = wd_cnt + 1'b1;
            end
`endif
         end
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         owner    <= '0;
         last     <= IW'(NUM_REQ - 1);
         ack      <= '0;
         done     <= '0;
         tx_valid <= 1'b0;
         tx_data  <= '0;
         busy     <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
         wd_cnt   <= '0;
         err      <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         owner    <= owner_nxt;
         last     <= last_nxt;
         ack      <= ack_nxt;
         done     <= done_nxt;
         tx_valid <= tx_valid_nxt;
         tx_data  <= tx_data_nxt;
         busy     <= (state_nxt != IDLE);
`ifdef UART_TX_ARB_TIMEOUT_EN
         wd_cnt   <= wd_nxt;
         err      <= err_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboard bench for uart_tx_arb: driver queues expected grants/dones, monitor checks them.
module tb_uart_tx_arb;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int TO = 100;

   logic              clk_sys = 1'b0;
   logic              rst_n   = 1'b0;
   logic [N-1:0]      req     = '0;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      ack, done;
   logic              tx_valid;
   logic [DW-1:0]     tx_data;
   logic              tx_done = 1'b0;
   logic              busy, err;

   always #5 clk_sys = ~clk_sys;

   uart_tx_arb #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk_sys(clk_sys), .rst_n(rst_n), .req(req), .req_data(req_data),
      .ack(ack), .done(done), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_done(tx_done), .busy(busy), .err(err)
   );

   int            tests = 0;
   int            fails = 0;
   int            ack_q[$];
   logic [DW-1:0] dat_q[$];
   int            done_q[$];
   logic [DW-1:0] rd [N];
   logic [N-1:0]  pend = '0;
   int            last_m = N - 1;
   bit            at_gap = 1'b0;
   bit            expect_err = 1'b0;

   always_comb begin
      req_data = '0;
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = rd[i];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference rule: first active requester at (last+1), (last+2), ... mod N.
   function automatic int rr(input logic [N-1:0] r, input int l);
      for (int k = 1; k <= N; k++)
         if (r[(l + k) % N]) return (l + k) % N;
      return -1;
   endfunction

   // Monitor
   bit            in_send = 1'b0;
   bit            gap_chk = 1'b0;
   logic [DW-1:0] cur;
   always @(negedge clk_sys) begin
      int e;
      logic [DW-1:0] d;
      if (!rst_n) begin
         in_send = 1'b0;
         gap_chk = 1'b0;
      end else begin
         if (gap_chk) begin
            chk("gap_then_idle", {busy, tx_valid}, 2'b00);
            gap_chk = 1'b0;
         end
         if (ack != '0) begin
            if (ack_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_ack: got %b expected none", ack);
            end else begin
               e = ack_q.pop_front();
               d = dat_q.pop_front();
               chk("ack_onehot", ack, 1 << e);
               chk("tx_valid_at_ack", tx_valid, 1);
               chk("tx_data_at_ack", tx_data, d);
               cur = d;
               in_send = 1'b1;
            end
         end else if (done != '0 || err) begin
            if (done != '0) begin
               if (done_q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL unexpected_done: got %b expected none", done);
               end else chk("done_owner", done, 1 << done_q.pop_front());
            end
            if (err) begin
               chk("err_expected", expect_err, 1);
               expect_err = 1'b0;
            end
            chk("gap_state", {busy, tx_valid}, 2'b10);
            in_send = 1'b0;
            gap_chk = 1'b1;
         end else if (in_send) begin
            chk("send_hold", {busy, tx_valid, tx_data}, {2'b11, cur});
         end
      end
   end

   task automatic idle(input int n);
      pend = '0;
      req  = '0;
      repeat (n) begin
         @(negedge clk_sys);
         tx_done = ($urandom_range(0, 2) == 0);
      end
      at_gap = 1'b0;
   endtask

   // mode 0: normal tx_done, 1: stop inside SEND, 2: withhold tx_done (watchdog)
   task automatic xact(input logic [N-1:0] add, input bit fixed, input logic [DW-1:0] base,
                       input int mode);
      int w, lat, k, r;
      for (int i = 0; i < N; i++)
         if (add[i] && !pend[i]) rd[i] = fixed ? DW'(int'(base) + i) : DW'($urandom);
      pend = pend | add;
      req  = pend;
      w = rr(pend, last_m);
      last_m = w;
      ack_q.push_back(w);
      dat_q.push_back(rd[w]);
      lat = at_gap ? 2 : 1;
      k = 0;
      do begin
         @(negedge clk_sys);
         tx_done = 1'b0;
         k++;
      end while (ack == '0 && k < 10);
      chk("ack_latency", k, lat);
      pend[w] = 1'b0;
      req = pend;
      rd[w] = 8'hFF;
      if (mode == 0) begin
         repeat ($urandom_range(0, 4)) begin
            @(negedge clk_sys);
            r = $urandom_range(0, N - 1);
            if (!pend[r] && $urandom_range(0, 1) == 1) begin
               rd[r] = DW'($urandom);
               pend[r] = 1'b1;
               req = pend;
            end
         end
         @(negedge clk_sys);
         tx_done = 1'b1;
         done_q.push_back(w);
         @(negedge clk_sys);
         tx_done = ($urandom_range(0, 3) == 0);
         at_gap = 1'b1;
      end else if (mode == 1) begin
         repeat (2) @(negedge clk_sys);
      end else begin
         expect_err = 1'b1;
         k = 0;
         do begin
            @(negedge clk_sys);
            k++;
         end while (!err && k < 3 * TO);
         chk("timeout_cycles", k, TO);
         at_gap = 1'b1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [N-1:0] add;
      for (int i = 0; i < N; i++) rd[i] = '0;
      repeat (2) @(negedge clk_sys);
      chk("reset_state", {ack, done, tx_valid, tx_data, busy, err}, 0);
      rst_n = 1'b1;
      @(negedge clk_sys);

      xact(4'b0001, 1'b1, 8'hC9, 0);
      idle(2);

      xact(4'b0010, 1'b1, 8'h5A, 1);
      #1 rst_n = 1'b0;
      #1 chk("rst_async", {ack, done, tx_valid, tx_data, busy, err}, 0);
      repeat (2) begin
         @(negedge clk_sys);
         tx_done = 1'b1;
      end
      tx_done = 1'b0;
      rst_n   = 1'b1;
      pend    = '0;
      req     = '0;
      last_m  = N - 1;
      at_gap  = 1'b0;
      @(negedge clk_sys);

      xact(4'b1111, 1'b1, 8'h10, 0);
      xact(4'b0000, 1'b0, 8'h00, 0);
      xact(4'b0000, 1'b0, 8'h00, 0);
      xact(4'b0001, 1'b1, 8'h10, 0);
      xact(4'b0000, 1'b0, 8'h00, 0);

      idle(2);
      xact(4'b0100, 1'b1, 8'h20, 0);
      xact(4'b0011, 1'b1, 8'h30, 0);
      xact(4'b0000, 1'b0, 8'h00, 0);

`ifdef UART_TX_ARB_TIMEOUT_EN
      idle(2);
      xact(4'b0100, 1'b1, 8'h77, 2);
`endif
      idle(2);

      for (int t = 0; t < 60; t++) begin
         add = N'($urandom);
         if ($urandom_range(0, 3) == 0) begin
            pend[$urandom_range(0, N - 1)] = 1'b0;
            req = pend;
         end
         if ((pend | add) == '0 || $urandom_range(0, 7) == 0) begin
            idle($urandom_range(1, 3));
            add = add | N'(1 << $urandom_range(0, N - 1));
         end
         xact(add, 1'b0, 8'h00, 0);
      end

      idle(4);
      chk("ack_q_drained", ack_q.size(), 0);
      chk("done_q_drained", done_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
